// File: rtl/int_ctrl.sv
// int_ctrl: small vectored interrupt controller feeding CP0 HWInt lines.
//
// Raw device lines are synchronized (q1 -> q2) and delayed once more (q3)
// for edge detection. Each source is either edge-triggered (MODE=1) or
// level-sensitive (MODE=0). Pending bits are gated by MASK. A three-state
// FSM (IDLE/ASSERT/GAP) picks the lowest-index eligible source, holds it
// on hwint/irq until software writes VEC (end of interrupt), then forces
// one quiet GAP cycle before the next arbitration.
//
// Register map (word offsets on addr):
//   0 PEND  read: pending bits; write: 1-to-clear, edge-mode bits only
//   1 MASK  RW enable per source
//   2 MODE  RW, 1 = edge, 0 = level
//   3 VEC   read: {active, 28'b0, id[2:0]}; write: EOI (only honoured in ASSERT)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   irq_src   raw interrupt lines (asynchronous to clk)
//   addr      register select
//   we        one-cycle write strobe
//   wdata     write data
//   rdata     combinational read data for addr, unused bits 0
//   hwint     one-hot id of the source being serviced (0 when not in ASSERT)
//   irq       interrupt request, |hwint
//   state_dbg current FSM state (0 IDLE, 1 ASSERT, 2 GAP)
//
// The id register is 3 bits wide, so NSRC must not exceed 8.

module int_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hwint,
  output logic            irq,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] q1_q, q1_d;
  logic [NSRC-1:0] q2_q, q2_d;
  logic [NSRC-1:0] q3_q, q3_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] hwint_q, hwint_d;
  logic [2:0]      id_q, id_d;

  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] eligible;
  logic [2:0]      winner;
  logic            wr_pend;
  logic            eoi;
  logic            clr;

  // Only the low NSRC bits of wdata are meaningful for the register file.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:NSRC];

  always_comb begin
    q1_d     = irq_src;
    q2_d     = q1_q;
    q3_d     = q2_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    state_d  = state_q;
    id_d     = id_q;
    hwint_d  = hwint_q;
    pend_d   = pend_q;
    clr      = 1'b0;

    edge_det = q2_q & ~q3_q;
    wr_pend  = we && (addr == 2'd0);
    // EOI outside ASSERT is ignored entirely, including its pend clear.
    eoi      = we && (addr == 2'd3) && (state_q == ST_ASSERT);

    if (we && (addr == 2'd1)) mask_d = wdata[NSRC-1:0];
    if (we && (addr == 2'd2)) mode_d = wdata[NSRC-1:0];

    // Edge mode: detection wins over a same-cycle clear (PEND write or EOI).
    // Level mode: pend simply mirrors the synchronized line.
    for (int i = 0; i < NSRC; i++) begin
      clr = (wr_pend && wdata[i]) || (eoi && (id_q == i[2:0]));
      if (mode_q[i]) pend_d[i] = edge_det[i] | (pend_q[i] & ~clr);
      else           pend_d[i] = q2_q[i];
    end

    eligible = pend_q & mask_q;
    winner   = 3'd0;
    // Scan downward so the lowest eligible index is the last assignment.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = i[2:0];
    end

    case (state_q)
      ST_IDLE: begin
        if (eligible != '0) begin
          state_d = ST_ASSERT;
          id_d    = winner;
          hwint_d = {{(NSRC-1){1'b0}}, 1'b1} << winner;
        end
      end
      ST_ASSERT: begin
        // Held until EOI regardless of source or mask changes.
        if (eoi) begin
          state_d = ST_GAP;
          hwint_d = '0;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        hwint_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        hwint_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_q    <= '0;
      q2_q    <= '0;
      q3_q    <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      id_q    <= 3'd0;
      hwint_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      q1_q    <= q1_d;
      q2_q    <= q2_d;
      q3_q    <= q3_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      hwint_q <= hwint_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      2'd0: rdata = {{(32-NSRC){1'b0}}, pend_q};
      2'd1: rdata = {{(32-NSRC){1'b0}}, mask_q};
      2'd2: rdata = {{(32-NSRC){1'b0}}, mode_q};
      2'd3: rdata = {(state_q == ST_ASSERT), 28'd0, id_q};
      default: rdata = 32'd0;
    endcase
  end

  assign hwint     = hwint_q;
  assign irq       = |hwint_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios with hand-computed expectations.
// Stimulus pushes expected values into a queue; a monitor process pops and
// compares them at the falling clock edge (or immediately on chk_now, for
// the asynchronous reset check).

module tb_int_ctrl;

  localparam int NSRC = 6;

  localparam int K_IRQ   = 0;
  localparam int K_HWINT = 1;
  localparam int K_RDATA = 2;
  localparam int K_STATE = 3;

  localparam logic [31:0] ST_IDLE   = 32'd0;
  localparam logic [31:0] ST_ASSERT = 32'd1;
  localparam logic [31:0] ST_GAP    = 32'd2;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] irq_src;
  logic [1:0]      addr;
  logic            we;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [NSRC-1:0] hwint;
  logic            irq;
  logic [1:0]      state_dbg;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];

  int checks = 0;
  int errors = 0;

  event chk_now;

  int_ctrl #(.NSRC(NSRC)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .hwint     (hwint),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [31:0] act;
    logic [31:0] e;
    int          k;
    string       nm;
    forever begin
      @(negedge clk or chk_now);
      while (kind_q.size() > 0) begin
        k  = kind_q.pop_front();
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        case (k)
          K_IRQ:   act = {31'd0, irq};
          K_HWINT: act = {{(32-NSRC){1'b0}}, hwint};
          K_RDATA: act = rdata;
          default: act = {30'd0, state_dbg};
        endcase
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int k, input logic [31:0] e, input string nm);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    addr = a;
    push(K_RDATA, e, nm);
    sample();
  endtask

  task automatic wait_irq(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL %s: irq got %b expected 1 within %0d cycles", nm, irq, max_cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    irq_src = '0;
    addr    = 2'd0;
    we      = 1'b0;
    wdata   = 32'd0;

    // Reset pulse: low at 3ns for 5ns.
    #3 reset = 1'b0;
    #5 reset = 1'b1;
    push(K_IRQ,   32'd0,   "rst_irq");
    push(K_HWINT, 32'd0,   "rst_hwint");
    push(K_STATE, ST_IDLE, "rst_state");
    sample();
    chk_rd(2'd0, 32'd0, "rst_pend");
    chk_rd(2'd1, 32'd0, "rst_mask");
    chk_rd(2'd2, 32'd0, "rst_mode");
    chk_rd(2'd3, 32'd0, "rst_vec");

    // Edge-mode latency on source 0: irq after the 4th rising edge.
    tick();
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h01);
    irq_src = 6'h01;
    ticks(3);
    push(K_IRQ,   32'd0,   "lat_irq_e2");
    push(K_STATE, ST_IDLE, "lat_state_e2");
    sample();
    tick();
    push(K_IRQ,   32'd1,   "lat_irq_e3");
    push(K_HWINT, 32'h01,  "lat_hwint_e3");
    sample();
    chk_rd(2'd3, 32'h8000_0000, "lat_vec");
    chk_rd(2'd0, 32'h1,         "lat_pend");
    wr(2'd3, 32'd0);
    push(K_IRQ,   32'd0,  "lat_eoi_irq");
    push(K_STATE, ST_GAP, "lat_eoi_gap");
    sample();
    ticks(2);
    chk_rd(2'd0, 32'h0, "lat_pend_cleared");
    irq_src = '0;
    ticks(4);

    // Priority: sources 2 and 5 together, all edge mode.
    wr(2'd2, 32'h3F);
    irq_src = 6'h24;
    ticks(4);
    push(K_IRQ,   32'd1,  "pri_irq");
    push(K_HWINT, 32'h04, "pri_hwint_2");
    sample();
    chk_rd(2'd3, 32'h8000_0002, "pri_vec_2");
    chk_rd(2'd0, 32'h24,        "pri_pend");
    irq_src = '0;
    wr(2'd3, 32'd0);
    push(K_IRQ,   32'd0,  "pri_gap_irq");
    push(K_STATE, ST_GAP, "pri_gap_state");
    sample();
    tick();
    push(K_STATE, ST_IDLE, "pri_gap_one_cycle");
    sample();
    wait_irq(4, "pri_second_irq");
    push(K_HWINT, 32'h20, "pri_hwint_5");
    sample();
    chk_rd(2'd3, 32'h8000_0005, "pri_vec_5");
    wr(2'd3, 32'd0);
    ticks(3);
    chk_rd(2'd0, 32'h0, "pri_pend_cleared");

    // Masking: source 3 in level mode with MASK=0.
    wr(2'd1, 32'h00);
    wr(2'd2, 32'h00);
    irq_src = 6'h08;
    ticks(4);
    push(K_IRQ, 32'd0, "msk_irq_blocked");
    sample();
    chk_rd(2'd0, 32'h8, "msk_pend");
    wr(2'd0, 32'h8);
    chk_rd(2'd0, 32'h8, "msk_w1c_level_ignored");
    wr(2'd1, 32'h08);
    wait_irq(2, "msk_irq_unmasked");
    push(K_HWINT, 32'h08, "msk_hwint");
    sample();
    irq_src = '0;
    ticks(4);
    push(K_IRQ,   32'd1,  "msk_hold_src_drop");
    push(K_HWINT, 32'h08, "msk_hold_hwint");
    sample();
    chk_rd(2'd0, 32'h0, "msk_level_pend_follows");
    wr(2'd1, 32'h00);
    push(K_IRQ, 32'd1, "msk_hold_mask_clear");
    sample();
    wr(2'd3, 32'd0);
    push(K_IRQ, 32'd0, "msk_eoi_irq");
    sample();
    ticks(2);
    push(K_STATE, ST_IDLE, "msk_idle");
    sample();
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h3F);

    // Collision: source 1 re-edges on the same clock as its EOI.
    irq_src = 6'h02;
    wait_irq(6, "col_first_irq");
    push(K_HWINT, 32'h02, "col_hwint_first");
    sample();
    irq_src = '0;
    ticks(3);
    irq_src = 6'h02;
    ticks(2);
    wr(2'd3, 32'd0);
    push(K_STATE, ST_GAP, "col_gap");
    sample();
    chk_rd(2'd0, 32'h2, "col_pend_kept");
    wait_irq(4, "col_reassert");
    push(K_HWINT, 32'h02, "col_hwint_again");
    sample();
    irq_src = '0;
    wr(2'd3, 32'd0);
    ticks(4);
    chk_rd(2'd0, 32'h0, "col_pend_cleared");

    // Reset during ASSERT: irq must fall without a clock edge.
    irq_src = 6'h10;
    wait_irq(6, "rst_mid_irq");
    push(K_HWINT, 32'h10, "rst_mid_hwint");
    sample();
    tick();
    #2 reset = 1'b0;
    #1;
    push(K_IRQ,   32'd0,   "rst_mid_irq_async");
    push(K_HWINT, 32'd0,   "rst_mid_hwint_async");
    push(K_STATE, ST_IDLE, "rst_mid_state_async");
    -> chk_now;
    #1;
    irq_src = '0;
    #2 reset = 1'b1;
    chk_rd(2'd0, 32'h0, "rst_mid_pend");
    chk_rd(2'd1, 32'h0, "rst_mid_mask");
    chk_rd(2'd3, 32'h0, "rst_mid_vec");
    push(K_STATE, ST_IDLE, "rst_mid_state_after");
    sample();

    sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
